// File: rtl/cmos_pixel_packer_if.sv
// Pixel-in / word-out stream bundle for the RGB565 pair packer.
// master = packer side, slave = capture source plus frame-buffer FIFO side.
interface cmos_pixel_packer_if;
  logic        cam_vsync;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eol;

  modport master (input  cam_vsync, pix_valid, pix_data, out_ready,
                  output out_valid, out_data, out_sof, out_eol);
  modport slave  (output cam_vsync, pix_valid, pix_data, out_ready,
                  input  out_valid, out_data, out_sof, out_eol);
endinterface

// File: rtl/cmos_pixel_packer.sv
// Packs RGB565 pixel pairs into 32-bit words with sof/eol tags, skips the
// sensor's settling frames and reports per-frame geometry status.
module cmos_pixel_packer #(
  parameter int H_PIXELS   = 1024,
  parameter int V_LINES    = 768,
  parameter int FRAME_SKIP = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  cmos_pixel_packer_if.master bus,
  output logic                frame_done,
  output logic                frame_ok,
  output logic [15:0]         frame_cnt
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES + 1);  // y must be able to reach V_LINES
  localparam int SW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
  } word_t;

  logic          vsync_d, vsync_rise;
  logic [SW-1:0] skip_cnt;
  logic          frame_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          phase;
  logic [15:0]   lo_pix;
  logic          ovf, excess;
  logic          accept, in_range, last_x, push, xfer;
  word_t         new_w, out_w, spill_w;
  logic          out_v, spill_v;

  assign vsync_rise = bus.cam_vsync & ~vsync_d;
  assign accept     = bus.pix_valid & frame_en & ~vsync_rise;
  assign in_range   = (y < YW'(V_LINES));
  assign last_x     = (x == XW'(H_PIXELS - 1));
  assign push       = accept & in_range & phase;
  assign xfer       = out_v & bus.out_ready;

  always_comb begin
    new_w      = '0;
    new_w.data = {bus.pix_data, lo_pix};
    new_w.sof  = (x == XW'(1)) && (y == '0);
    new_w.eol  = last_x;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_d    <= 1'b0;
      skip_cnt   <= '0;
      frame_en   <= 1'b0;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      lo_pix     <= '0;
      ovf        <= 1'b0;
      excess     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_d    <= bus.cam_vsync;
      frame_done <= 1'b0;
      if (vsync_rise) begin
        frame_cnt <= frame_cnt + 16'd1;
        x         <= '0;
        y         <= '0;
        phase     <= 1'b0;
        ovf       <= 1'b0;
        excess    <= 1'b0;
        // Judge the frame that just ended; a dangling half-pair fails it.
        if (frame_en) begin
          frame_done <= 1'b1;
          frame_ok   <= (y == YW'(V_LINES)) & ~phase & ~ovf & ~excess;
        end
        if (skip_cnt < SW'(FRAME_SKIP)) begin
          skip_cnt <= skip_cnt + SW'(1);
          frame_en <= 1'b0;
        end else begin
          frame_en <= 1'b1;
        end
      end else if (accept) begin
        if (!in_range) begin
          excess <= 1'b1;
        end else begin
          phase <= ~phase;
          if (!phase) lo_pix <= bus.pix_data;
          if (last_x) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end
      if (push & out_v & spill_v & ~xfer) ovf <= 1'b1;
    end
  end

  // Two-entry FIFO: out_w is what the consumer sees, spill_w queues behind it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_v   <= 1'b0;
      spill_v <= 1'b0;
      out_w   <= '0;
      spill_w <= '0;
    end else if (!out_v) begin
      if (push) begin
        out_v <= 1'b1;
        out_w <= new_w;
      end
    end else if (xfer) begin
      if (spill_v) begin
        out_w <= spill_w;
        if (push) spill_w <= new_w;
        else      spill_v <= 1'b0;
      end else if (push) begin
        out_w <= new_w;
      end else begin
        out_v <= 1'b0;
      end
    end else if (push & ~spill_v) begin
      spill_v <= 1'b1;
      spill_w <= new_w;
    end
  end

  assign bus.out_valid = out_v;
  assign bus.out_data  = out_w.data;
  assign bus.out_sof   = out_w.sof;
  assign bus.out_eol   = out_w.eol;
endmodule
